// File: rtl/alu_arb_pkg.sv
// Shared types for the ALU arbiter: operation encoding and the ID-width helper.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    function automatic int id_width(input int m);
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational N-bit ALU; results wrap modulo 2^N with carry/borrow discarded.
module alu
    import alu_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  alu_op_e        op,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic [N-1:0]   y
);

    always_comb begin
        y = '0;
        unique case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter_rr_arbiter.sv
// Rotating-priority arbiter: the search starts one past ptr and wraps at M-1.
module rr_arbiter #(
    parameter int M   = 4,
    parameter int IDW = 2
) (
    input  logic [M-1:0]   req,
    input  logic           en,
    input  logic [IDW-1:0] ptr,
    output logic [M-1:0]   grant,
    output logic [IDW-1:0] idx
);

    logic found;
    int   cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= M; k++) begin
            cand = (int'(ptr) + k) % M;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = en;
                idx         = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among M valid/ready requesters with a registered, held response.
// Define ALU_ARB_RR_EN for round-robin; otherwise the lowest valid index always wins.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N   = 4,
    parameter int M   = 4,
    parameter int IDW = id_width(M)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [M-1:0]     req_valid,
    output logic [M-1:0]     req_ready,
    input  logic [M*N-1:0]   req_opnd1,
    input  logic [M*N-1:0]   req_opnd2,
    input  logic [M*2-1:0]   req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [N-1:0]     rsp_result
);

    logic           can_issue;
    logic [M-1:0]   grant;
    logic [IDW-1:0] win_idx;
    logic [IDW-1:0] ptr;
    logic [N-1:0]   alu_a;
    logic [N-1:0]   alu_b;
    alu_op_e        alu_op;
    logic [N-1:0]   alu_y;

    // Grants are suppressed during reset so no operation is lost to a dropped response.
    assign can_issue = (!rsp_valid || rsp_ready) && !reset;
    assign req_ready = grant;

`ifdef ALU_ARB_RR_EN
    logic [IDW-1:0] last;

    always_ff @(posedge clk) begin
        if (reset)
            last <= IDW'(M - 1);
        else if (|grant)
            last <= win_idx;
    end

    assign ptr = last;
`else
    // A pointer pinned at M-1 makes the rotating search a fixed lowest-index priority.
    assign ptr = IDW'(M - 1);
`endif

    rr_arbiter #(
        .M   (M),
        .IDW (IDW)
    ) u_arb (
        .req   (req_valid),
        .en    (can_issue),
        .ptr   (ptr),
        .grant (grant),
        .idx   (win_idx)
    );

    assign alu_a  = req_opnd1[win_idx*N +: N];
    assign alu_b  = req_opnd2[win_idx*N +: N];
    assign alu_op = alu_op_e'(req_op[win_idx*2 +: 2]);

    alu #(
        .N (N)
    ) u_alu (
        .op (alu_op),
        .a  (alu_a),
        .b  (alu_b),
        .y  (alu_y)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
        end else if (|grant) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= win_idx;
            rsp_result <= alu_y;
        end else if (rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: vector table plus fairness, backpressure and reset sequences.
module tb_alu_arbiter;
    localparam int N   = 4;
    localparam int M   = 4;
    localparam int IDW = 2;

    logic             clk;
    logic             reset;
    logic [M-1:0]     req_valid;
    logic [M-1:0]     req_ready;
    logic [M*N-1:0]   req_opnd1;
    logic [M*N-1:0]   req_opnd2;
    logic [M*2-1:0]   req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [N-1:0]     rsp_result;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_arbiter #(.N(N), .M(M)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_opnd1  (req_opnd1),
        .req_opnd2  (req_opnd2),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         rq;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp_res;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        req_opnd1[i*N +: N] = a;
        req_opnd2[i*N +: N] = b;
        req_op[i*2 +: 2]    = op;
    endtask

    task automatic fill_background();
        // Distinct non-winner operands make a wrong mux select visible.
        for (int i = 0; i < M; i++)
            set_req(i, 2'b11, 4'(i + 9), 4'(i * 3));
    endtask

    logic [M-1:0] onehot;
    int           exp_grant [5];

    initial begin
        reset     = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        req_opnd1 = '0;
        req_opnd2 = '0;
        req_op    = '0;

        vecs[0] = '{2, 2'b00, 4'h3, 4'h5, 4'h8};
        vecs[1] = '{1, 2'b00, 4'hF, 4'h2, 4'h1};
        vecs[2] = '{1, 2'b01, 4'h2, 4'h3, 4'hF};
        vecs[3] = '{1, 2'b10, 4'hC, 4'hA, 4'h8};
        vecs[4] = '{1, 2'b11, 4'hC, 4'hA, 4'hE};
        vecs[5] = '{3, 2'b01, 4'h0, 4'h1, 4'hF};
        vecs[6] = '{0, 2'b11, 4'h5, 4'hA, 4'hF};
        vecs[7] = '{2, 2'b10, 4'hF, 4'h3, 4'h3};

        // Reset held two cycles with every requester valid.
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check("reset_req_ready", 32'(req_ready), 32'h0);
            check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
            check("reset_rsp_id", 32'(rsp_id), 32'h0);
            check("reset_rsp_result", 32'(rsp_result), 32'h0);
        end

        // Fairness: all valid, requester i adds i+0 so result equals owner id.
`ifdef ALU_ARB_RR_EN
        exp_grant = '{0, 1, 2, 3, 0};
`else
        exp_grant = '{0, 0, 0, 0, 0};
`endif
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < M; i++) set_req(i, 2'b00, 4'(i), 4'h0);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            if (k != 0) @(negedge clk);
            #1;
            onehot = 4'b0001 << exp_grant[k];
            check("fair_req_ready", 32'(req_ready), 32'(onehot));
            @(posedge clk); #1;
            check("fair_rsp_id", 32'(rsp_id), 32'(exp_grant[k]));
            check("fair_rsp_result", 32'(rsp_result), 32'(exp_grant[k]));
        end

        // Single-request vector table.
        for (int v = 0; v < 8; v++) begin
            @(negedge clk);
            fill_background();
            set_req(vecs[v].rq, vecs[v].op, vecs[v].a, vecs[v].b);
            req_valid = 4'b0001 << vecs[v].rq;
            #1;
            check($sformatf("vec%0d_req_ready", v), 32'(req_ready), 32'(4'b0001 << vecs[v].rq));
            @(posedge clk); #1;
            check($sformatf("vec%0d_rsp_valid", v), 32'(rsp_valid), 32'h1);
            check($sformatf("vec%0d_rsp_id", v), 32'(rsp_id), 32'(vecs[v].rq));
            check($sformatf("vec%0d_rsp_result", v), 32'(rsp_result), 32'(vecs[v].exp_res));
        end

        // Backpressure: load a response, stall three cycles, then release.
        @(negedge clk);
        fill_background();
        set_req(0, 2'b00, 4'h7, 4'h0);
        req_valid = 4'b0001;
        @(posedge clk); #1;
        check("bp_load_id", 32'(rsp_id), 32'h0);
        check("bp_load_result", 32'(rsp_result), 32'h7);
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(1, 2'b10, 4'h6, 4'h3);
        req_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_req_ready", 32'(req_ready), 32'h0);
            @(posedge clk); #1;
            check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
            check("bp_rsp_id", 32'(rsp_id), 32'h0);
            check("bp_rsp_result", 32'(rsp_result), 32'h7);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_req_ready", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        check("bp_release_rsp_id", 32'(rsp_id), 32'h1);
        check("bp_release_rsp_result", 32'(rsp_result), 32'h2);

        // Reset while a response is held and requests are pending.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 4'b0110;
        reset     = 1'b1;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("midrst_rsp_id", 32'(rsp_id), 32'h0);
        check("midrst_rsp_result", 32'(rsp_result), 32'h0);
        @(negedge clk);
        reset     = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < M; i++) set_req(i, 2'b00, 4'(i), 4'h4);
        req_valid = 4'b1111;
        #1;
        check("postrst_req_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        check("postrst_rsp_valid", 32'(rsp_valid), 32'h1);
        check("postrst_rsp_id", 32'(rsp_id), 32'h0);
        check("postrst_rsp_result", 32'(rsp_result), 32'h4);
        @(negedge clk);
        req_valid = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
